// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - request/grant, response and memory-side signals of mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [2:0]        d_funct3;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [2:0]        mem_funct3;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [15:0]       conflict_cnt;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_read, mem_write, mem_funct3, mem_addr, mem_wdata, conflict_cnt
  );

  // Pipeline/memory side
  modport master (
    output if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_read, mem_write, mem_funct3, mem_addr, mem_wdata, conflict_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - data-priority arbiter for fetch/data ports sharing one memory port
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int D_BASE     = 200,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]     STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] D_OFS      = ADDR_W'(D_BASE);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;

  owner_e        owner_q, owner_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [15:0]   conflict_q, conflict_d;
  logic          force_if, d_win, if_gnt, d_gnt;

  always_comb begin
    force_if = (starve_q == STARVE_TOP);
    d_win    = bus.d_req && !(force_if && bus.if_req);
    d_gnt    = !rst && d_win;
    if_gnt   = !rst && bus.if_req && !d_win;
  end

  always_comb begin
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_funct3 = 3'b000;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    if (d_gnt) begin
      bus.mem_read   = !bus.d_we;
      bus.mem_write  = bus.d_we;
      bus.mem_funct3 = bus.d_funct3;
      bus.mem_addr   = bus.d_addr + D_OFS;
      bus.mem_wdata  = bus.d_wdata;
    end else if (if_gnt) begin
      bus.mem_read   = 1'b1;
      bus.mem_funct3 = 3'b010;
      bus.mem_addr   = bus.if_addr;
    end
  end

  // Only reads leave an owner behind; stores finish at the granting edge.
  always_comb begin
    owner_d    = OWN_NONE;
    starve_d   = starve_q;
    conflict_d = conflict_q;
    if (if_gnt)
      owner_d = OWN_IF;
    else if (d_gnt && !bus.d_we)
      owner_d = OWN_D;
    if (if_gnt)
      starve_d = '0;
    else if (bus.if_req && starve_q != STARVE_TOP)
      starve_d = starve_q + 1'b1;
    if (bus.if_req && bus.d_req && conflict_q != 16'hFFFF)
      conflict_d = conflict_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q    <= OWN_NONE;
      starve_q   <= '0;
      conflict_q <= '0;
    end else begin
      owner_q    <= owner_d;
      starve_q   <= starve_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.if_gnt       = if_gnt;
  assign bus.d_gnt        = d_gnt;
  assign bus.if_rvalid    = (owner_q == OWN_IF);
  assign bus.d_rvalid     = (owner_q == OWN_D);
  assign bus.if_rdata     = bus.mem_rdata;
  assign bus.d_rdata      = bus.mem_rdata;
  assign bus.conflict_cnt = conflict_q;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-ported unified memory between the pipeline's instruction-fetch port and its data (load/store) port. It sits between the IF/MEM stages and the memory. Each cycle it issues at most one access. The data port has default priority; a bounded-starvation rule guarantees fetch progress. It tracks the owner of each outstanding read and routes the 1-cycle-latency read data back to that requester. This replaces ad-hoc address muxing and NOP injection with an explicit grant/valid handshake.

## Interface
- ADDR_W, 8, memory byte-address width
- DATA_W, 32, data width
- D_BASE, 200, offset added to every data-port address (data region base)
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch gets forced priority (must be ≥1)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch address (word-aligned)
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetched instruction
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_funct3  in  3  RV32 access size/sign (LB/LH/LW/LBU/LHU/SB/SH/SW encoding)
- d_addr  in  ADDR_W  data address before offset
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data access accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_W  load data
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_funct3  out  3  access size to memory
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_read
- conflict_cnt  out  16  saturating count of cycles in which both ports requested

## Operation
- Grant selection is combinational from the current requests and the registered starvation state:
  - force_if = (starve_cnt == STARVE_MAX).
  - If d_req && !(force_if && if_req): d_gnt=1, if_gnt=0.
  - Otherwise, if if_req: if_gnt=1.
  - If neither is requesting, no grant.
- Memory drive:
  - Data grant: mem_addr = (d_addr + D_BASE) truncated to ADDR_W; mem_funct3 = d_funct3; mem_write = d_we; mem_read = !d_we; mem_wdata = d_wdata.
  - Fetch grant: mem_addr = if_addr; mem_funct3 = 3'b010; mem_read = 1; mem_write = 0.
  - No grant: mem_read = mem_write = 0; address, funct3 and wdata are 0.
- Owner register `owner` ∈ {NONE, IF, D}:
  - Loaded each edge with IF on a fetch grant, D on a data read grant, NONE otherwise. Stores load NONE.
  - if_rvalid = (owner==IF); d_rvalid = (owner==D).
  - if_rdata and d_rdata both pass mem_rdata through. Each is only meaningful when its rvalid is high.
- Starvation counter `starve_cnt`, width clog2(STARVE_MAX+1):
  - Increments by 1 when if_req && !if_gnt, saturating at STARVE_MAX.
  - Clears to 0 on any if_gnt.
  - Holds when if_req = 0.
- conflict_cnt increments by 1 on each edge where if_req && d_req, saturating at 16'hFFFF.
- Stores complete at the granting edge. No response is returned for a store.

## Timing
- Reset (async assert, sync to clk release):
  - owner = NONE, starve_cnt = 0, conflict_cnt = 0.
  - Therefore if_rvalid = d_rvalid = 0 immediately.
  - While rst is high, grants and mem strobes are forced to 0.
- Handshake: a request is accepted on the rising edge where req && gnt. The requester must hold its request and its address/data stable until that edge. Requests may be dropped without being granted.
- Read latency: data arrives exactly 1 cycle after the grant edge, with rvalid for one cycle. Back-to-back grants produce back-to-back rvalids, giving a throughput of 1 access/cycle.
- Simultaneous requests: data wins unless force_if. When fetch is forced, data is denied that cycle, and starve_cnt clears on the following edge.
- Reset asserted mid-read: the outstanding response is discarded, and no rvalid appears after reset releases.
- Address wrap: d_addr + D_BASE wraps modulo 2^ADDR_W, with no error signal.

## Test plan
- Reset: assert rst mid-fetch → if_rvalid = 0 within the same cycle. After release, starve_cnt = 0, conflict_cnt = 0, and no stray rvalid.
- Fetch only: if_req held, if_addr = 0, 4, 8 → if_gnt every cycle; if_rvalid every cycle from cycle 2 onward; if_rdata = mem words at 0, 4, 8 in order; mem_funct3 = 3'b010.
- Load vs fetch conflict: both requesting for 1 cycle with d_addr = 4, LW → d_gnt = 1, mem_addr = 204, d_rvalid next cycle, if_gnt deferred 1 cycle; conflict_cnt = 1.
- Starvation (STARVE_MAX = 4): d_req and if_req both held high → d_gnt for 4 cycles, if_gnt on the 5th cycle, d_gnt on the 6th; the pattern repeats with period 5.
- Store: SW d_addr = 8, d_wdata = 32'hDEADBEEF → mem_write = 1, mem_addr = 208, no d_rvalid. A subsequent LW at d_addr = 8 returns 32'hDEADBEEF.
- Wrap and saturation: d_addr = 8'd100 → mem_addr = 8'd44 (300 mod 256). Holding both requests for 70000 cycles → conflict_cnt = 16'hFFFF and holds there.
